// File: rtl/tiny_dnn_pkg.sv
// Shared constants and state encoding for the tiny_dnn neuron sequencer.
package tiny_dnn_pkg;
  localparam int F_SIZE = 1024;
  localparam int ADR_W  = 10;
  localparam logic [ADR_W-1:0] BIAS_ADR = ADR_W'(F_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_BIAS,
    S_DRAIN,
    S_FIN
  } seq_state_t;
endpackage

// File: rtl/tiny_dnn_seq.sv
// Sequencer for one tiny_dnn_core MAC neuron: weight-load phase and
// compute phase (N exec cycles, one bias cycle, drain, result strobe).
module tiny_dnn_seq #(
  parameter int f_size = tiny_dnn_pkg::F_SIZE,
  parameter int ADR_W  = tiny_dnn_pkg::ADR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADR_W-1:0] cfg_len,
  input  logic             load_start,
  input  logic             run_start,
  input  logic             w_valid,
  output logic             w_ready,
  output logic             init,
  output logic             write,
  output logic             bwrite,
  output logic             exec,
  output logic             bias,
  output logic [ADR_W-1:0] ra,
  output logic [ADR_W-1:0] wa,
  output logic [ADR_W-1:0] in_adr,
  output logic             busy,
  output logic             sum_valid,
  output logic             done
);
  import tiny_dnn_pkg::*;

  localparam logic [ADR_W-1:0] LEN_MAX = ADR_W'(f_size - 2);
  localparam logic [ADR_W-1:0] BADR    = ADR_W'(f_size - 1);

  seq_state_t       state_q, state_d;
  logic [ADR_W-1:0] k_q, k_d;
  logic [ADR_W-1:0] len_q, len_d;
  logic [ADR_W-1:0] in_adr_q, in_adr_d;
  logic             run_q, run_d;
  logic [ADR_W-1:0] cfg_clamp;

  // Clamp keeps the data slots clear of the bias slot at f_size-1.
  assign cfg_clamp = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      len_q    <= '0;
      in_adr_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      len_q    <= len_d;
      in_adr_q <= in_adr_d;
      run_q    <= run_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    len_d     = len_q;
    in_adr_d  = in_adr_q;
    run_d     = run_q;
    w_ready   = 1'b0;
    init      = 1'b0;
    write     = 1'b0;
    bwrite    = 1'b0;
    exec      = 1'b0;
    bias      = 1'b0;
    ra        = '0;
    wa        = '0;
    sum_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          len_d   = cfg_clamp;
          k_d     = '0;
          run_d   = 1'b0;
        end else if (run_start) begin
          len_d = cfg_clamp;
          k_d   = '0;
          run_d = 1'b1;
          if (cfg_clamp == '0) begin
            state_d = S_BIAS;
          end else begin
            state_d  = S_EXEC;
            in_adr_d = '0;
          end
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        wa      = k_q;
        if (w_valid) begin
          write = 1'b1;
          if (k_q == len_q) begin
            bwrite  = 1'b1;
            state_d = S_FIN;
          end else begin
            k_d = k_q + ADR_W'(1);
          end
        end
      end
      S_EXEC: begin
        exec = 1'b1;
        ra   = k_q;
        init = (k_q == '0);
        k_d  = k_q + ADR_W'(1);
        // The buffer read address runs in lockstep with k and freezes on the last data word.
        if (k_q == len_q - ADR_W'(1)) state_d = S_BIAS;
        else                          in_adr_d = k_q + ADR_W'(1);
      end
      S_BIAS: begin
        bias    = 1'b1;
        ra      = BADR;
        init    = (len_q == '0);
        state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_FIN;
      S_FIN: begin
        done      = 1'b1;
        sum_valid = run_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_adr = in_adr_q;
  assign busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Directed bench for tiny_dnn_seq with a cycle-level phase model and a small core/buffer model.
module tb_tiny_dnn_seq;
  logic       clk = 1'b0, reset = 1'b1;
  logic [9:0] cfg_len = '0;
  logic       load_start = 1'b0, run_start = 1'b0, w_valid = 1'b0;
  logic       w_ready, init, write, bwrite, exec, bias, busy, sum_valid, done;
  logic [9:0] ra, wa, in_adr;

  tiny_dnn_seq dut (
    .clk(clk), .reset(reset), .cfg_len(cfg_len), .load_start(load_start),
    .run_start(run_start), .w_valid(w_valid), .w_ready(w_ready), .init(init),
    .write(write), .bwrite(bwrite), .exec(exec), .bias(bias), .ra(ra), .wa(wa),
    .in_adr(in_adr), .busy(busy), .sum_valid(sum_valid), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cycle = 0;
  logic chk_en = 1'b0;

  // Core + input-buffer model: registered buffer read, one-cycle exec/bias delay.
  real wd = 0.0, sum = 0.0, dbuf = 0.0, exp_sum = 0.0;
  logic exp_sum_en = 1'b0;
  real wram [1024];
  real din  [1024];
  logic exec1 = 1'b0, bias1 = 1'b0;
  logic [9:0] ra1 = '0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      wram[i] = 0.0;
      din[i]  = (i < 16) ? 1.0 : 0.0;
    end
  end

  always @(posedge clk) begin
    if (write) wram[bwrite ? 10'd1023 : wa] <= wd;
    dbuf  <= din[in_adr];
    exec1 <= exec;
    bias1 <= bias;
    ra1   <= ra;
    if (exec1)      sum <= sum + wram[ra1] * dbuf;
    else if (bias1) sum <= sum + wram[1023];
    else if (init)  sum <= 0.0;
  end

  // Phase model: mode 0 idle, 1 loading, 2 load finished, 3 running (m_cyc = cycle index).
  int m_mode = 0, m_n = 0, m_acc = 0, m_cyc = 0, m_adr = 0;

  function automatic int clamp_len(input logic [9:0] l);
    return (int'(l) > 1022) ? 1022 : int'(l);
  endfunction

  always @(posedge clk) begin
    cycle++;
    if (reset) begin
      m_mode = 0;
      m_adr  = 0;
    end else begin
      case (m_mode)
        0: if (load_start) begin
             m_n = clamp_len(cfg_len); m_acc = 0; m_mode = 1;
           end else if (run_start) begin
             m_n = clamp_len(cfg_len); m_cyc = 0; m_mode = 3;
           end
        1: if (w_valid) begin
             if (m_acc == m_n) m_mode = 2;
             else m_acc++;
           end
        2: m_mode = 0;
        default: begin
          if (m_cyc < m_n) m_adr = m_cyc;
          if (m_cyc == m_n + 2) m_mode = 0;
          else m_cyc++;
        end
      endcase
    end
  end

  function automatic logic [38:0] expected();
    logic wr, in, wt, bw, ex, bi, bu, sv, dn;
    int era, ewa, eia;
    {wr, in, wt, bw, ex, bi, bu, sv, dn} = '0;
    era = 0; ewa = 0; eia = m_adr;
    if (m_mode == 1) begin
      wr = 1; bu = 1; wt = w_valid; ewa = m_acc;
      bw = w_valid && (m_acc == m_n);
    end else if (m_mode == 2) begin
      bu = 1; dn = 1;
    end else if (m_mode == 3) begin
      bu = 1;
      if (m_cyc < m_n) begin
        ex = 1; era = m_cyc; eia = m_cyc; in = (m_cyc == 0);
      end else if (m_cyc == m_n) begin
        bi = 1; era = 1023; in = (m_n == 0);
      end else if (m_cyc == m_n + 2) begin
        sv = 1; dn = 1;
      end
    end
    return {wr, in, wt, bw, ex, bi, bu, sv, dn, 10'(era), 10'(ewa), 10'(eia)};
  endfunction

  int n_write, n_bwrite, n_exec, n_init, n_bias, n_done, n_sumv, n_busy, n_wready, bw_wa;

  task automatic clr();
    n_write = 0; n_bwrite = 0; n_exec = 0; n_init = 0; n_bias = 0;
    n_done = 0; n_sumv = 0; n_busy = 0; n_wready = 0; bw_wa = -1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [38:0] got, exp_v;
      got   = {w_ready, init, write, bwrite, exec, bias, busy, sum_valid, done, ra, wa, in_adr};
      exp_v = expected();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d got %h exp %h", cycle, got, exp_v);
      end
      if (exec && bias) begin
        errors++;
        $display("FAIL exec_and_bias cycle %0d got both high exp exclusive", cycle);
      end
      n_write += int'(write); n_bwrite += int'(bwrite); n_exec += int'(exec);
      n_init += int'(init); n_bias += int'(bias); n_done += int'(done);
      n_sumv += int'(sum_valid); n_busy += int'(busy); n_wready += int'(w_ready);
      if (bwrite) bw_wa = int'(wa);
      if (sum_valid && exp_sum_en) begin
        checks++;
        if (sum - exp_sum > 1.0e-9 || exp_sum - sum > 1.0e-9) begin
          errors++;
          $display("FAIL sum cycle %0d got %f exp %f", cycle, sum, exp_sum);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp_i);
    checks++;
    if (got != exp_i) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp_i);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  real wq [8];

  task automatic do_load(input logic [9:0] len, input int nw, input logic [31:0] vpat);
    int wi;
    wi = 0;
    cfg_len = len; load_start = 1'b1;
    cyc(1);
    load_start = 1'b0;
    for (int c = 0; c < 32 && wi < nw; c++) begin
      w_valid = vpat[c];
      wd = wq[wi];
      cyc(1);
      if (vpat[c]) wi++;
    end
    w_valid = 1'b0;
    cyc(2);
  endtask

  task automatic do_run(input logic [9:0] len, input int ncyc);
    cfg_len = len; run_start = 1'b1;
    cyc(1);
    run_start = 1'b0;
    cyc(ncyc);
  endtask

  initial begin
    clr();
    @(posedge clk); #1;
    chk_en = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_in_adr", int'(in_adr), 0);

    // Load N=3, w_valid held high.
    clr();
    wq[0] = 9.0; wq[1] = 9.0; wq[2] = 9.0; wq[3] = 9.0;
    do_load(10'd3, 4, 32'hFFFF_FFFF);
    chk("load3_writes", n_write, 4);
    chk("load3_bwrite", n_bwrite, 1);
    chk("load3_bw_wa", bw_wa, 3);
    chk("load3_busy", n_busy, 5);
    chk("load3_done", n_done, 1);

    // Load N=2 with w_valid toggling 1,0,1,0,1.
    clr();
    do_load(10'd2, 3, 32'b10101);
    chk("load2_writes", n_write, 3);
    chk("load2_bw_wa", bw_wa, 2);
    chk("load2_wready", n_wready, 5);

    // Weights {1,2,3,4}, bias 0.5; run N=4 with d=1.
    clr();
    wq[0] = 1.0; wq[1] = 2.0; wq[2] = 3.0; wq[3] = 4.0; wq[4] = 0.5;
    do_load(10'd4, 5, 32'hFFFF_FFFF);
    clr();
    exp_sum = 10.5; exp_sum_en = 1'b1;
    do_run(10'd4, 8);
    chk("run4_exec", n_exec, 4);
    chk("run4_init", n_init, 1);
    chk("run4_bias", n_bias, 1);
    chk("run4_sumv", n_sumv, 1);

    // Bias-only neuron: N=0, bias 2.0.
    wq[0] = 2.0;
    do_load(10'd0, 1, 32'hFFFF_FFFF);
    clr();
    exp_sum = 2.0;
    do_run(10'd0, 4);
    chk("run0_exec", n_exec, 0);
    chk("run0_init", n_init, 1);
    chk("run0_sumv", n_sumv, 1);

    // Both starts at once: load wins, run_start held through LOAD and FIN is ignored.
    clr();
    cfg_len = 10'd1; load_start = 1'b1; run_start = 1'b1;
    cyc(1);
    load_start = 1'b0; w_valid = 1'b1; wd = 3.0;
    cyc(1);
    wd = 0.25;
    cyc(1);
    w_valid = 1'b0;
    cyc(1);
    run_start = 1'b0;
    cyc(4);
    chk("both_writes", n_write, 2);
    chk("both_exec", n_exec, 0);
    chk("both_done", n_done, 1);

    // Reset in cycle 2 of an N=8 run, then a clean N=1 run.
    clr();
    cfg_len = 10'd8; run_start = 1'b1;
    cyc(1);
    run_start = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    cyc(2);
    chk("abort_done", n_done, 0);
    chk("abort_sumv", n_sumv, 0);
    clr();
    exp_sum = 3.25;
    do_run(10'd1, 5);
    chk("run1_sumv", n_sumv, 1);

    // Oversized cfg_len clamps to f_size-2 exec cycles.
    clr();
    exp_sum_en = 1'b0;
    do_run(10'd1023, 1026);
    chk("clamp_exec", n_exec, 1022);
    chk("clamp_sumv", n_sumv, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tiny_dnn_seq.md
Name: tiny_dnn_seq

Overview:
Sequencer for one tiny_dnn_core multiply-accumulate neuron.
- Runs a weight-load phase: streams N weights plus one bias into the core weight RAM.
- Runs a compute phase: issues N exec cycles, then one bias cycle, then flags when the core's sum is valid.
- Sits between the layer-level controller and a single core.
- Also drives the read address of the external input-activation buffer, so d arrives aligned with the core's internal exec delay.

Parameters:
- f_size, 1024: core weight RAM depth. Address f_size-1 is reserved for the bias.
- ADR_W, 10: address width, equal to log2(f_size).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_len  in  ADR_W  number of inputs N (0..f_size-2). Sampled when load_start or run_start is accepted.
- load_start  in  1  request a weight-load phase.
- run_start  in  1  request a compute phase.
- w_valid  in  1  upstream weight/bias word valid. The wd data bypasses this block straight to the core.
- w_ready  out  1  weight stream ready.
- init  out  1  to core: clear sum.
- write  out  1  to core: weight write enable.
- bwrite  out  1  to core: write to the bias slot.
- exec  out  1  to core: MAC read.
- bias  out  1  to core: bias read.
- ra  out  ADR_W  to core: read address.
- wa  out  ADR_W  to core: write address.
- in_adr  out  ADR_W  read address to the input buffer. The buffer has a registered read, so d is valid one cycle later.
- busy  out  1  high in any state other than IDLE.
- sum_valid  out  1  one-cycle pulse: core sum holds the final result this cycle.
- done  out  1  one-cycle pulse at the end of either phase.

Behaviour:
- Reset: state goes to IDLE. All outputs are 0, and all counters and the latched length are 0. The core's sum is not cleared; the next run's init clears it.
- Reset mid-phase aborts the phase immediately. No done pulse is issued. A partially loaded weight set is not valid.
- States: IDLE, LOAD, EXEC, BIAS, DRAIN, FIN.
- Start acceptance (IDLE only):
  - load_start has priority over run_start if both are high.
  - Starts are ignored while busy.
  - The accepting cycle latches len = min(cfg_len, f_size-2) and clears counter k.
- LOAD:
  - w_ready = 1.
  - Each cycle with w_valid=1: write = 1 (combinational w_valid & w_ready) and wa = k.
  - When k == len: bwrite = 1 also, so the word lands in f_size-1. The next state is FIN. Otherwise k increments.
  - With w_valid = 0, nothing is written and k holds.
  - Exactly len+1 words are accepted.
- Compute timing: cycle 0 is the cycle after run_start is accepted.
  - EXEC, cycles 0..N-1: exec = 1, ra = in_adr = k, k increments.
  - init = 1 in cycle 0 only. The core's exec1 path takes precedence next cycle, so sum starts from 0.
  - If N == 0, skip EXEC and go straight to BIAS. init and bias are then both asserted in cycle 0.
  - BIAS, cycle N: bias = 1, exec = 0, ra = f_size-1, in_adr held.
  - DRAIN, cycle N+1: all core controls 0 while the core applies the bias.
  - FIN, cycle N+2: sum_valid = 1 and done = 1. Return to IDLE.
  - Total latency from run_start to sum_valid is N+3 cycles.
- After a load, FIN asserts done only (sum_valid = 0). FIN takes one cycle.
- exec and bias are never both high. write is never high outside LOAD.
- Counter k never exceeds len. There is no address wrap: len is clamped so the data slots never overlap the bias slot.
- A back-to-back start in the same cycle as FIN is ignored. It is accepted from IDLE on the next cycle.

Decomposition:
- Package tiny_dnn_pkg holds:
  - F_SIZE and ADR_W constants;
  - BIAS_ADR = F_SIZE-1;
  - the state enum seq_state_t.
- No sub-module: a single FSM plus one counter and one length register. Expected size is about 150 lines.

Test Plan:
- Load with cfg_len=3 and w_valid held high: write high for 4 cycles with wa = 0,1,2,3; bwrite only on the 4th; done the cycle after; busy for 5 cycles total.
- Load with cfg_len=2 and w_valid toggling 1,0,1,0,1: exactly 3 writes with wa = 0,1,2; bwrite on the 3rd; w_ready stays 1 throughout LOAD.
- Run with N=4, attached to a core model, weights {1,2,3,4} bias 0.5, d = {1,1,1,1}: exec in cycles 0-3 with ra = 0..3 and init only in cycle 0; bias in cycle 4; sum_valid in cycle 6 with sum = 10.5.
- Run with N=0, bias 2.0: init and bias in cycle 0; sum_valid in cycle 2 with sum = 2.0; exec never asserted.
- load_start and run_start both high in IDLE: LOAD entered. A run_start asserted during LOAD is ignored, and no exec appears after done.
- Reset asserted in cycle 2 of a run with N=8: next cycle all outputs 0 and busy = 0, with no done/sum_valid. A following run with N=1 gives the correct sum, cleared by init.
